// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
// Holds the NOP encoding, the buffered entry layout and the wrapped pointer increment.
package fetch_pkg;

    localparam int FQ_XLEN    = 32;
    localparam int PTR_CALC_W = 5;

    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] ins;
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] pcp4;
    } fetch_entry_t;

    // Explicit compare against depth-1 so non-power-of-two depths wrap correctly.
    function automatic logic [PTR_CALC_W-1:0] ptr_inc(
        input logic [PTR_CALC_W-1:0] ptr,
        input logic [PTR_CALC_W-1:0] depth
    );
        logic [PTR_CALC_W-1:0] w_nxt;
        if (ptr == (depth - 5'd1)) begin
            w_nxt = 5'd0;
        end else begin
            w_nxt = ptr + 5'd1;
        end
        return w_nxt;
    endfunction

endpackage

// File: rtl/fq_ptr.sv
// Circular-buffer pointer: advances on enable, wraps at DEPTH-1,
// synchronously cleared by reset or flush.
module fq_ptr
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_nxt;

    // Wrapped successor of the current pointer.
    always_comb begin
        w_nxt = PW'(ptr_inc(PTR_CALC_W'(r_ptr), PTR_CALC_W'(DEPTH)));
    end

    // Pointer register; clear wins over advance.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_ptr <= {PW{1'b0}};
        end else if (i_en) begin
            r_ptr <= w_nxt;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode; WIDTH up to FQ_XLEN.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int WIDTH  = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_ins,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_pcp4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ins,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pcp4,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [CW-1:0] r_cnt;

    logic [PW-1:0] w_wp;
    logic [PW-1:0] w_rp;
    logic          w_clr;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_skip_write;
    fetch_entry_t  w_wr_entry;
    fetch_entry_t  w_head;

    assign w_clr   = reset | flush;
    assign w_empty = (r_cnt == CNT_ZERO);
    assign w_full  = (r_cnt == CNT_FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass     = w_empty & in_valid & ~flush;
    assign w_skip_write = w_bypass & out_ready;
`else
    assign w_skip_write = 1'b0;
`endif

    // in_ready depends only on registered occupancy, so a full queue refuses a push even if decode pops.
    assign in_ready = ~w_full;
    assign w_push   = in_valid & in_ready & ~w_clr & ~w_skip_write;
    assign w_pop    = ~w_empty & out_ready & ~w_clr;

    assign w_wr_entry.ins  = FQ_XLEN'(in_ins);
    assign w_wr_entry.pc   = FQ_XLEN'(in_pc);
    assign w_wr_entry.pcp4 = FQ_XLEN'(in_pcp4);
    assign w_head          = r_mem[w_rp];

    fq_ptr #(.DEPTH(DEPTH)) u_wp (
        .i_clk (clk),
        .i_clr (w_clr),
        .i_en  (w_push),
        .o_ptr (w_wp)
    );

    fq_ptr #(.DEPTH(DEPTH)) u_rp (
        .i_clk (clk),
        .i_clr (w_clr),
        .i_en  (w_pop),
        .o_ptr (w_rp)
    );

    // Occupancy counter; reset/flush take priority over push and pop.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_cnt <= CNT_ZERO;
        end else if (w_push && !w_pop) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else if (w_pop && !w_push) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // Entry storage; contents are masked at the outputs whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wp] <= w_wr_entry;
        end
    end

    // Head presentation: queued entry, optional bypass, otherwise NOP with zero PCs.
    always_comb begin
        out_valid = 1'b0;
        out_ins   = WIDTH'(NOP_INS);
        out_pc    = {WIDTH{1'b0}};
        out_pcp4  = {WIDTH{1'b0}};
        if (!w_empty) begin
            out_valid = 1'b1;
            out_ins   = WIDTH'(w_head.ins);
            out_pc    = WIDTH'(w_head.pc);
            out_pcp4  = WIDTH'(w_head.pcp4);
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (w_bypass) begin
            out_valid = 1'b1;
            out_ins   = in_ins;
            out_pc    = in_pc;
            out_pcp4  = in_pcp4;
        end
`endif
        else begin
            out_valid = 1'b0;
        end
    end

    assign count = r_cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table on a DEPTH=2 instance, streaming
// across pointer wrap on a DEPTH=3 instance, bypass check when FETCH_QUEUE_BYPASS_EN is set.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'h0050_0093;
    localparam logic [31:0] IB  = 32'h0010_0113;
    localparam logic [31:0] IC  = 32'h0020_0193;
    localparam logic [31:0] ID  = 32'h0030_0213;
    localparam logic [31:0] IE  = 32'h0040_0293;
    localparam logic [31:0] IF  = 32'h0060_0313;
    localparam logic [31:0] IG  = 32'h0070_0393;
    localparam logic [31:0] IH  = 32'h0080_0413;
    localparam logic [31:0] II  = 32'h0090_0493;
    localparam logic [31:0] IJ  = 32'h00a0_0513;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [31:0] a_in_ins, a_in_pc, a_in_pcp4, a_out_ins, a_out_pc, a_out_pcp4;
    logic [1:0]  a_count;

    logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [31:0] b_in_ins, b_in_pc, b_in_pcp4, b_out_ins, b_out_pc, b_out_pcp4;
    logic [1:0]  b_count;

    fetch_queue #(.DEPTH(2), .WIDTH(32)) u_dut2 (
        .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ins(a_in_ins), .in_pc(a_in_pc), .in_pcp4(a_in_pcp4),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ins(a_out_ins),
        .out_pc(a_out_pc), .out_pcp4(a_out_pcp4), .flush(a_flush), .count(a_count)
    );

    fetch_queue #(.DEPTH(3), .WIDTH(32)) u_dut3 (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ins(b_in_ins), .in_pc(b_in_pc), .in_pcp4(b_in_pcp4),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ins(b_out_ins),
        .out_pc(b_out_pc), .out_pcp4(b_out_pcp4), .flush(b_flush), .count(b_count)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        ordy;
        logic        ev;
        logic [31:0] eins;
        logic [31:0] epc;
        logic [1:0]  ecnt;
        logic        eir;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vt [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        ev;
        logic [31:0] eins, epc, epcp4;
        int          sent, got, cyc, maxcnt;
        logic        tog;

        // Expected outputs describe the cycle in which the row's inputs are applied.
        //          rst   flush iv    ins  pc      ordy  ev    eins epc     ecnt  eir
        vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0, NOP, 32'h00, 2'd0, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 1'b1, IA, 32'h00, 1'b0, 1'b0, NOP, 32'h00, 2'd0, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 1'b1, IB, 32'h04, 1'b0, 1'b1, IA,  32'h00, 2'd1, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 1'b1, IC, 32'h08, 1'b0, 1'b1, IA,  32'h00, 2'd2, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, IC, 32'h08, 1'b1, 1'b1, IA,  32'h00, 2'd2, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, IC, 32'h08, 1'b0, 1'b1, IB,  32'h04, 2'd1, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00, 1'b1, 1'b1, IB, 32'h04, 2'd2, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00, 1'b1, 1'b1, IC, 32'h08, 2'd1, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0, NOP, 32'h00, 2'd0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b1, ID, 32'h0c, 1'b0, 1'b0, NOP, 32'h00, 2'd0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b1, IE, 32'h10, 1'b0, 1'b1, ID,  32'h0c, 2'd1, 1'b1};
        vt[11] = '{1'b0, 1'b1, 1'b1, IF, 32'h14, 1'b1, 1'b1, ID,  32'h0c, 2'd2, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0, NOP, 32'h00, 2'd0, 1'b1};
        vt[13] = '{1'b0, 1'b0, 1'b1, IG, 32'h18, 1'b0, 1'b0, NOP, 32'h00, 2'd0, 1'b1};
        vt[14] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00, 1'b1, 1'b1, IG, 32'h18, 2'd1, 1'b1};
        vt[15] = '{1'b0, 1'b0, 1'b1, IH, 32'h1c, 1'b0, 1'b0, NOP, 32'h00, 2'd0, 1'b1};
        vt[16] = '{1'b0, 1'b0, 1'b1, II, 32'h20, 1'b0, 1'b1, IH,  32'h1c, 2'd1, 1'b1};
        vt[17] = '{1'b1, 1'b0, 1'b1, IJ, 32'h24, 1'b1, 1'b1, IH,  32'h1c, 2'd2, 1'b0};
        vt[18] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0, NOP, 32'h00, 2'd0, 1'b1};
        vt[19] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h00, 1'b1, 1'b0, NOP, 32'h00, 2'd0, 1'b1};
        vt[20] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0, NOP, 32'h00, 2'd0, 1'b1};

        a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_in_ins = 32'h0; a_in_pc = 32'h0; a_in_pcp4 = 32'h0;
        b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_ins = 32'h0; b_in_pc = 32'h0; b_in_pcp4 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            a_reset     = vt[i].rst;
            a_flush     = vt[i].flush;
            a_in_valid  = vt[i].iv;
            a_in_ins    = vt[i].ins;
            a_in_pc     = vt[i].pc;
            a_in_pcp4   = vt[i].pc + 32'd4;
            a_out_ready = vt[i].ordy;
            @(negedge clk);
            ev   = vt[i].ev;
            eins = vt[i].eins;
            epc  = vt[i].epc;
`ifdef FETCH_QUEUE_BYPASS_EN
            if (vt[i].ecnt == 2'd0 && vt[i].iv && !vt[i].flush) begin
                ev   = 1'b1;
                eins = vt[i].ins;
                epc  = vt[i].pc;
            end
`endif
            epcp4 = ev ? epc + 32'd4 : 32'h0;
            chk($sformatf("vec%0d out_valid", i), 32'(a_out_valid), 32'(ev));
            chk($sformatf("vec%0d out_ins", i), a_out_ins, eins);
            chk($sformatf("vec%0d out_pc", i), a_out_pc, epc);
            chk($sformatf("vec%0d out_pcp4", i), a_out_pcp4, epcp4);
            chk($sformatf("vec%0d count", i), 32'(a_count), 32'(vt[i].ecnt));
            chk($sformatf("vec%0d in_ready", i), 32'(a_in_ready), 32'(vt[i].eir));
            @(posedge clk);
            #1;
        end
        a_reset = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;

        // Stream ten instructions through the DEPTH=3 queue with out_ready toggling.
        sent = 0; got = 0; cyc = 0; maxcnt = 0; tog = 1'b1;
        while (got < 10 && cyc < 300) begin
            b_in_valid  = (sent < 10);
            b_in_ins    = 32'hA000_0000 + 32'(sent);
            b_in_pc     = 32'h0000_0100 + 32'(sent * 4);
            b_in_pcp4   = 32'h0000_0104 + 32'(sent * 4);
            b_out_ready = tog;
            @(negedge clk);
            if (int'(b_count) > maxcnt) maxcnt = int'(b_count);
            if (b_out_valid && b_out_ready) begin
                chk($sformatf("stream%0d ins", got), b_out_ins, 32'hA000_0000 + 32'(got));
                chk($sformatf("stream%0d pc", got), b_out_pc, 32'h0000_0100 + 32'(got * 4));
                chk($sformatf("stream%0d pcp4", got), b_out_pcp4, 32'h0000_0104 + 32'(got * 4));
                got++;
            end
            if (b_in_valid && b_in_ready) sent++;
            @(posedge clk);
            #1;
            tog = ~tog;
            cyc++;
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        chk("stream delivered", 32'(got), 32'd10);
        chk("stream max count", 32'(maxcnt), 32'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stream drained valid", 32'(b_out_valid), 32'd0);
        chk("stream drained count", 32'(b_count), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        @(posedge clk);
        #1;
        a_in_valid  = 1'b1;
        a_in_ins    = 32'h0000_0513;
        a_in_pc     = 32'h0000_0020;
        a_in_pcp4   = 32'h0000_0024;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bypass out_valid", 32'(a_out_valid), 32'd1);
        chk("bypass out_pc", a_out_pc, 32'h0000_0020);
        chk("bypass out_ins", a_out_ins, 32'h0000_0513);
        chk("bypass count same cycle", 32'(a_count), 32'd0);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("bypass count after", 32'(a_count), 32'd0);
        chk("bypass out_valid after", 32'(a_out_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and the decode stage.
- Captures {ins, PC, PC+4} triples from fetch and presents them in order to decode over a valid/ready handshake.
- Decouples decode stalls from the PC register.
- Discards all buffered instructions on a redirect (branch, jump or interrupt) signalled by the PC-select logic.

Parameters:
- DEPTH, 2, number of entries; legal values 2..16, any integer (not restricted to powers of two).
- WIDTH, 32, instruction and address width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents a valid triple.
- in_ready  out  1  queue accepts the triple this cycle.
- in_ins  in  WIDTH  fetched instruction.
- in_pc  in  WIDTH  PC of in_ins.
- in_pcp4  in  WIDTH  in_pc + 4.
- out_valid  out  1  head entry valid for decode.
- out_ready  in  1  decode consumes the head this cycle.
- out_ins  out  WIDTH  head instruction.
- out_pc  out  WIDTH  head PC.
- out_pcp4  out  WIDTH  head PC+4.
- flush  in  1  redirect; discard all contents.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries with write pointer wp, read pointer rp and occupancy cnt.
- Pointer wrap: each pointer wraps from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
- Push: fires when in_valid && in_ready. Entry is written at wp; wp advances.
- Pop: fires when out_valid && out_ready. rp advances.
- in_ready = (cnt != DEPTH). It is a function of registered state only and has no combinational path from out_ready.
- Full with simultaneous pop: the push is refused that cycle (in_ready = 0). Push is accepted on the next cycle.
- Push and pop in the same cycle with 0 < cnt < DEPTH: cnt is unchanged; both pointers advance.
- out_valid = (cnt != 0). Latency is 1 cycle: an entry pushed in cycle N is visible at the outputs in cycle N+1.
- Output data when out_valid = 0:
  - out_ins = NOP (32'h00000013, addi x0,x0,0).
  - out_pc = 0.
  - out_pcp4 = 0.
  - Decode therefore never sees stale data.
- Handshake stability: while out_valid && !out_ready, the head outputs hold stable until popped.
- Fetch keeps its payload stable while in_valid && !in_ready.
- Flush (priority over push and pop):
  - The next cycle has cnt = 0, wp = rp = 0, out_valid = 0.
  - A push or pop requested in the flush cycle has no effect.
  - in_ready is still driven from the current cnt during the flush cycle; the triple is dropped regardless.
- Reset, asserted in any cycle (including mid-stream with a full queue): next cycle has cnt = 0, wp = rp = 0, out_valid = 0, in_ready = 1, data outputs at NOP/0.
- reset and flush together: identical to reset.
- count = cnt, registered.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When cnt == 0 && in_valid && !flush, the input triple drives the outputs combinationally and out_valid = 1 in the same cycle.
  - If out_ready is also high, the triple is consumed without being written; cnt, wp and rp are unchanged.
  - Otherwise the triple is written normally.
  - Latency is 0 cycles when empty.
- Undefined: latency is always 1 cycle, and no combinational path exists from any in_* port to any out_* port.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INS = 32'h00000013.
  - Struct fetch_entry_t {ins, pc, pcp4}.
  - Function ptr_inc(ptr, depth), which returns the wrapped increment.
- Sub-module fq_ptr: a pointer register with enable, synchronous clear (flush|reset) and wrap at DEPTH-1.
  - Instantiated twice, once for wp and once for rp.

Test Plan:
1. Reset then idle -> out_valid = 0, out_ins = 32'h00000013, in_ready = 1, count = 0.
2. Push A (ins 32'h00500093, pc 0x0) and B (pc 0x4) with out_ready = 0:
   - count reaches 2 and in_ready = 0.
   - With out_ready held high, decode receives A and then B in order, each with correct pcp4 (0x4, 0x8).
3. Full queue, in_valid = 1 and out_ready = 1 in the same cycle -> only the pop occurs (count 2 -> 1); the pending input is accepted in the following cycle.
4. Stream 10 instructions with DEPTH = 3 and out_ready toggling 1,0,1,0 -> all 10 delivered in order with no loss or duplication across pointer wrap.
5. Queue holding 2 entries, flush = 1 together with in_valid = 1 -> next cycle count = 0 and out_valid = 0; the flush-cycle input never appears at the output.
6. With FETCH_QUEUE_BYPASS_EN defined and the queue empty, push pc 0x20 with out_ready = 1 -> out_valid = 1 and out_pc = 0x20 in the same cycle; count stays 0.
